lcd1602_sequencer: RTL and testbench
====================================

// Module: lcd1602_sequencer
// PURPOSE
//  Controller for the LCD 1602A 4-bit driver. Generates the driver's delay-flag vector and
//  runs the power-on init sequence. Then it accepts characters/commands from a user stream,
//  handles cursor wrap between the two lines, and issues each byte to the driver with correct
//  enable/ready sequencing and post-command settle delays. Sits between the application logic
//  and the driver.
// PARAMETERS
//  NFLAGS    7       width-1 of flags vector to driver (7 flags used, bits 6..0)
//  TMO_CYC   4096    driver handshake timeout in clk cycles
//  COLS      16      characters per line before wrap
// PORTS
//  clk          in   1   system clock, 20 MHz
//  rst          in   1   synchronous, active-high reset
//  wr_valid     in   1   user byte valid
//  wr_ready     out  1   sequencer can accept a byte this cycle
//  wr_data      in   8   character code or command byte
//  wr_is_cmd    in   1   1: wr_data is a command (RS=0), 0: character (RS=1)
//  drv_rdy      in   1   driver idle/ready
//  drv_count    in   1   driver request to restart flag timer
//  drv_enable   out  1   start/hold driver transfer
//  drv_is_data  out  1   RS value for current transfer
//  drv_data     out  8   byte for driver, stable while drv_enable=1
//  drv_flags    out  NFLAGS+1  delay checkpoints to driver
//  init_done    out  1   init sequence finished
//  busy         out  1   transfer or settle delay in progress
//  err          out  1   sticky: handshake timeout
// BEHAVIOUR
//  Reset: all outputs 0 (drv_flags=0, wr_ready=0). State=PWR_WAIT. Cursor col=0, line=0.
//  Flag timer: 19-bit saturating counter. Cleared to 0 in the cycle after drv_count=1, else +1.
//   drv_flags[i]=1 when count>=TH[i]. TH: [6]40ns=1, [5]250ns=5, [4]42us=840, [3]100us=2000,
//   [2]1640us=32800, [1]4100us=82000, [0]15000us=300000. Bit 7 is tied 0.
//  Wait timer: separate 19-bit down-counter. Loaded at end of each transfer. WAIT exits at 0.
//  FSM: PWR_WAIT -> INIT_ISSUE -> IDLE -> ISSUE -> XFER -> SETTLE -> IDLE/WRAP.
//   PWR_WAIT: wait 300000 cycles (15 ms) from reset release, then INIT_ISSUE.
//   INIT ROM, in order, RS=0, with settle time: 0x33 (82000), 0x32 (2000), 0x28 (840),
//   0x0C (840), 0x06 (840), 0x01 (32800). After the last settle: init_done=1, go to IDLE.
//   IDLE: wr_ready=1. On wr_valid&wr_ready, latch data/is_cmd, go to ISSUE. wr_ready=0
//   otherwise.
//   ISSUE/XFER handshake:
//    - drv_enable=1 with drv_data/drv_is_data held.
//    - Wait for drv_rdy=0 (busy seen), then for drv_rdy=1.
//    - drv_enable drops the cycle after drv_rdy=1 is sampled. Then go to SETTLE.
//   SETTLE: 840 cycles. Exception: commands 0x01/0x02 use 32800 cycles.
//  Cursor rules:
//   - Characters: col+1 after SETTLE.
//   - col==COLS after a char: go to WRAP, issue 0x80|(line?0x00:0x40) as an internal command
//     (840 settle), toggle line, col=0.
//   - User command 0x01 or 0x02: col=0, line=0.
//   - User command with bit7=1 (DDRAM set): line=bit6, col=data[3:0].
//  Timeout: in XFER, more than TMO_CYC cycles without the expected drv_rdy edge -> err=1,
//   drv_enable=0, return to IDLE. err clears only on rst.
//  busy=1 in every state except IDLE. busy=0 from reset until PWR_WAIT starts.
//  wr_valid while busy is ignored; the user must hold wr_valid (valid/ready).
//  rst mid-transfer: drv_enable=0 next cycle, full init re-runs.
// TESTING
//  1 reset, run 15 ms -> six init bytes 33,32,28,0C,06,01 in order with RS=0;
//    spacing >= 82000/2000/840/840/840 cycles; init_done=1 after 32800 more cycles.
//  2 write 'A'(0x41) after init -> drv_is_data=1, drv_data=0x41; wr_ready low until 840
//    cycles after drv_rdy returns.
//  3 write 16 chars -> extra command 0xC0 issued after the 16th. Write 16 more -> 0x80.
//  4 write command 0x01 -> settle 32800 cycles; the next char lands at col 0, line 0.
//  5 tie drv_rdy=1 during XFER -> err=1 after TMO_CYC cycles, drv_enable=0, wr_ready=1.
//  6 assert rst mid-XFER -> drv_enable=0 next cycle, all outputs 0, init sequence repeats.

Source files
------------

// File: rtl/lcd1602_sequencer.sv
// lcd1602_sequencer: power-on init, cursor tracking and byte handshake in front of
// a 4-bit LCD1602 driver, plus the driver's delay-checkpoint flag vector.
module lcd1602_sequencer #(
  parameter int NFLAGS       = 7,
  parameter int TMO_CYC      = 4096,
  parameter int COLS         = 16,
  parameter int PWR_CYC      = 300000,
  parameter int INIT0_SETTLE = 82000,
  parameter int INIT1_SETTLE = 2000,
  parameter int SHORT_SETTLE = 840,
  parameter int LONG_SETTLE  = 32800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_is_cmd_i,
  input  logic            drv_rdy_i,
  input  logic            drv_count_i,
  output logic            drv_enable_o,
  output logic            drv_is_data_o,
  output logic [7:0]      drv_data_o,
  output logic [NFLAGS:0] drv_flags_o,
  output logic            init_done_o,
  output logic            busy_o,
  output logic            err_o
);
  localparam int TW = $clog2(TMO_CYC + 2);
  localparam logic [18:0] CNT_MAX = '1;

  typedef enum logic [2:0] {PWR_WAIT, INIT_ISSUE, IDLE, ISSUE, XFER, SETTLE, WRAP} state_e;
  typedef enum logic [1:0] {SRC_INIT, SRC_USER, SRC_WRAP} src_e;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [2:0]  romIdx_q, romIdx_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        seenBusy_q, seenBusy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [18:0] wait_q, wait_d;
  logic [18:0] cnt_q, cnt_d;
  logic [4:0]  col_q, col_d, colInc;
  logic        line_q, line_d;
  logic        drvEnable_q, drvEnable_d;
  logic        drvIsData_q, drvIsData_d;
  logic [7:0]  drvData_q, drvData_d;
  logic        wrReady_q, wrReady_d;
  logic        busy_q, busy_d;
  logic        initDone_q, initDone_d;
  logic        err_q, err_d;
  logic        isHomeCmd;
  logic [18:0] settleLen;

  function automatic logic [7:0] romByte(input logic [2:0] idx);
    case (idx)
      3'd0:    romByte = 8'h33;
      3'd1:    romByte = 8'h32;
      3'd2:    romByte = 8'h28;
      3'd3:    romByte = 8'h0C;
      3'd4:    romByte = 8'h06;
      default: romByte = 8'h01;
    endcase
  endfunction

  function automatic logic [18:0] romSettle(input logic [2:0] idx);
    case (idx)
      3'd0:    romSettle = 19'(INIT0_SETTLE);
      3'd1:    romSettle = 19'(INIT1_SETTLE);
      3'd5:    romSettle = 19'(LONG_SETTLE);
      default: romSettle = 19'(SHORT_SETTLE);
    endcase
  endfunction

  // Thresholds are in 50 ns clock cycles; bit 7 is unused by the driver.
  always_comb begin
    drv_flags_o    = '0;
    drv_flags_o[6] = cnt_q >= 19'd1;
    drv_flags_o[5] = cnt_q >= 19'd5;
    drv_flags_o[4] = cnt_q >= 19'd840;
    drv_flags_o[3] = cnt_q >= 19'd2000;
    drv_flags_o[2] = cnt_q >= 19'd32800;
    drv_flags_o[1] = cnt_q >= 19'd82000;
    drv_flags_o[0] = cnt_q >= 19'd300000;
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    romIdx_d    = romIdx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    seenBusy_d  = seenBusy_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    col_d       = col_q;
    line_d      = line_q;
    drvEnable_d = drvEnable_q;
    drvIsData_d = drvIsData_q;
    drvData_d   = drvData_q;
    initDone_d  = initDone_q;
    err_d       = err_q;
    colInc      = col_q + 5'd1;
    isHomeCmd   = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
    cnt_d       = drv_count_i ? 19'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 19'd1);

    if (src_q == SRC_INIT)  settleLen = romSettle(romIdx_q);
    else if (isHomeCmd)     settleLen = 19'(LONG_SETTLE);
    else                    settleLen = 19'(SHORT_SETTLE);

    case (state_q)
      PWR_WAIT: begin
        if (wait_q == 19'd0) state_d = INIT_ISSUE;
        else                 wait_d  = wait_q - 19'd1;
      end
      INIT_ISSUE: begin
        byte_d  = romByte(romIdx_q);
        rs_d    = 1'b0;
        src_d   = SRC_INIT;
        state_d = ISSUE;
      end
      IDLE: begin
        if (wr_valid_i && wrReady_q) begin
          byte_d  = wr_data_i;
          rs_d    = !wr_is_cmd_i;
          src_d   = SRC_USER;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        drvEnable_d = 1'b1;
        drvData_d   = byte_q;
        drvIsData_d = rs_q;
        seenBusy_d  = 1'b0;
        tmo_d       = '0;
        state_d     = XFER;
      end
      // The driver must first go busy, then come back ready; each edge restarts the timeout.
      XFER: begin
        if (!seenBusy_q && !drv_rdy_i) begin
          seenBusy_d = 1'b1;
          tmo_d      = '0;
        end else if (seenBusy_q && drv_rdy_i) begin
          drvEnable_d = 1'b0;
          wait_d      = settleLen;
          state_d     = SETTLE;
        end else if (tmo_q == TW'(TMO_CYC)) begin
          err_d       = 1'b1;
          drvEnable_d = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETTLE: begin
        if (wait_q != 19'd0) begin
          wait_d = wait_q - 19'd1;
        end else begin
          state_d = IDLE;
          case (src_q)
            SRC_INIT: begin
              if (romIdx_q == 3'd5) initDone_d = 1'b1;
              else begin
                romIdx_d = romIdx_q + 3'd1;
                state_d  = INIT_ISSUE;
              end
            end
            SRC_USER: begin
              if (rs_q) begin
                col_d = colInc;
                if (colInc == 5'(COLS)) state_d = WRAP;
              end else if (isHomeCmd) begin
                col_d  = 5'd0;
                line_d = 1'b0;
              end else if (byte_q[7]) begin
                col_d  = {1'b0, byte_q[3:0]};
                line_d = byte_q[6];
              end
            end
            default: ;
          endcase
        end
      end
      WRAP: begin
        byte_d  = line_q ? 8'h80 : 8'hC0;
        rs_d    = 1'b0;
        line_d  = !line_q;
        col_d   = 5'd0;
        src_d   = SRC_WRAP;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase

    wrReady_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      src_q       <= SRC_INIT;
      romIdx_q    <= 3'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      seenBusy_q  <= 1'b0;
      tmo_q       <= '0;
      wait_q      <= 19'(PWR_CYC);
      cnt_q       <= 19'd0;
      col_q       <= 5'd0;
      line_q      <= 1'b0;
      drvEnable_q <= 1'b0;
      drvIsData_q <= 1'b0;
      drvData_q   <= 8'h00;
      wrReady_q   <= 1'b0;
      busy_q      <= 1'b0;
      initDone_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      romIdx_q    <= romIdx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      seenBusy_q  <= seenBusy_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      line_q      <= line_d;
      drvEnable_q <= drvEnable_d;
      drvIsData_q <= drvIsData_d;
      drvData_q   <= drvData_d;
      wrReady_q   <= wrReady_d;
      busy_q      <= busy_d;
      initDone_q  <= initDone_d;
      err_q       <= err_d;
    end
  end

  assign wr_ready_o    = wrReady_q;
  assign drv_enable_o  = drvEnable_q;
  assign drv_is_data_o = drvIsData_q;
  assign drv_data_o    = drvData_q;
  assign init_done_o   = initDone_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_lcd1602_sequencer.sv
// Bench for lcd1602_sequencer with scaled-down delays, a small driver model and a
// transfer-level reference model of init bytes, cursor wrap and settle spacing.
module tb_lcd1602_sequencer;
  localparam int TMO = 64;
  localparam int PWR = 300;
  localparam int S0  = 820;
  localparam int S1  = 200;
  localparam int SS  = 84;
  localparam int SL  = 328;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, wr_is_cmd;
  logic [7:0] wr_data;
  logic       drv_rdy, drv_count;
  logic       drv_enable, drv_is_data;
  logic [7:0] drv_data, drv_flags;
  logic       init_done, busy, err;

  always #5 clk = ~clk;

  lcd1602_sequencer #(
    .NFLAGS(7), .TMO_CYC(TMO), .COLS(16), .PWR_CYC(PWR), .INIT0_SETTLE(S0),
    .INIT1_SETTLE(S1), .SHORT_SETTLE(SS), .LONG_SETTLE(SL)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_data_i(wr_data), .wr_is_cmd_i(wr_is_cmd), .drv_rdy_i(drv_rdy),
    .drv_count_i(drv_count), .drv_enable_o(drv_enable), .drv_is_data_o(drv_is_data),
    .drv_data_o(drv_data), .drv_flags_o(drv_flags), .init_done_o(init_done),
    .busy_o(busy), .err_o(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rs; logic [7:0] data; int startCyc; int endCyc; } xfer_t;
  typedef struct { bit rs; logic [7:0] data; int settle; } exp_t;
  typedef struct { int k; logic [7:0] flags; } flagVec_t;
  xfer_t monQ[$];
  exp_t  expQ[$];
  int    rdIdx = 0;
  int    modelCol, modelLine;
  bit    drvStuck = 0;
  bit    open = 0;
  bit    prevInit = 0;
  int    initDoneCyc = 0;

  // Records every driver transfer: contents at enable rise, cycle of enable fall.
  always @(negedge clk) begin
    if (drv_enable && !open) begin
      xfer_t x;
      x.rs = drv_is_data; x.data = drv_data; x.startCyc = cyc; x.endCyc = 0;
      monQ.push_back(x);
      open = 1;
    end else if (!drv_enable && open) begin
      if (monQ.size() > 0) monQ[monQ.size()-1].endCyc = cyc;
      open = 0;
    end
    if (init_done && !prevInit) initDoneCyc = cyc;
    prevInit = init_done;
  end

  // Driver model: goes busy a little after enable, returns ready a few cycles later.
  initial begin
    drv_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (drv_enable && !drvStuck) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        drv_rdy = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        drv_rdy = 1'b1;
        while (drv_enable) @(negedge clk);
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkAtLeast(input string nm, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected >= %0d", nm, act, lim);
    end
  endtask

  task automatic failTimeout(input string nm);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait expired, expected event", nm);
  endtask

  task automatic applyStimulus(input bit isCmd, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_is_cmd = isCmd;
    while (!wr_ready && n < 20000) begin @(negedge clk); n++; end
    if (!wr_ready) failTimeout("wr_ready");
    else begin @(posedge clk); @(negedge clk); end
    wr_valid = 1'b0;
  endtask

  task automatic waitIdle(input string nm);
    int n = 0;
    while (!wr_ready && n < 20000) begin @(negedge clk); n++; end
    if (!wr_ready) failTimeout(nm);
  endtask

  task automatic waitEnable(input logic lvl, input string nm);
    int n = 0;
    while (drv_enable !== lvl && n < 200) begin @(negedge clk); n++; end
    if (drv_enable !== lvl) failTimeout(nm);
  endtask

  function automatic logic [7:0] flagsFor(input int k);
    int th[7] = '{300000, 82000, 32800, 2000, 840, 5, 1};
    logic [7:0] f = 8'h00;
    for (int i = 0; i < 7; i++) if (k >= th[i]) f[i] = 1'b1;
    return f;
  endfunction

  function automatic void pushExp(input bit rs, input logic [7:0] d, input int settle);
    exp_t e;
    e.rs = rs; e.data = d; e.settle = settle;
    expQ.push_back(e);
  endfunction

  function automatic void modelInit();
    logic [7:0] bytes[6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
    int settles[6] = '{S0, S1, SS, SS, SS, SL};
    for (int i = 0; i < 6; i++) pushExp(1'b0, bytes[i], settles[i]);
    modelCol = 0; modelLine = 0;
  endfunction

  // Display memory view: line 0 starts at DDRAM 0x00, line 1 at 0x40.
  function automatic void modelWrite(input bit isCmd, input logic [7:0] d);
    bit home = isCmd && (d == 8'h01 || d == 8'h02);
    pushExp(!isCmd, d, home ? SL : SS);
    if (!isCmd) begin
      modelCol = modelCol + 1;
      if (modelCol == 16) begin
        modelLine = 1 - modelLine;
        modelCol  = 0;
        pushExp(1'b0, 8'(128 + 64 * modelLine), SS);
      end
    end else if (home) begin
      modelCol = 0; modelLine = 0;
    end else if (d >= 8'h80) begin
      modelLine = (int'(d) / 64) % 2;
      modelCol  = int'(d) % 16;
    end
  endfunction

  task automatic compareAll();
    while (rdIdx < monQ.size()) begin
      if (rdIdx >= expQ.size()) begin
        checkOutput("extra_xfer", monQ[rdIdx].data, 32'hFFFF_FFFF);
      end else begin
        checkOutput("xfer_data", monQ[rdIdx].data, expQ[rdIdx].data);
        checkOutput("xfer_rs", monQ[rdIdx].rs, expQ[rdIdx].rs);
        if (rdIdx > 0 && expQ[rdIdx-1].settle > 0)
          checkAtLeast("settle_gap", monQ[rdIdx].startCyc - monQ[rdIdx-1].endCyc,
                       expQ[rdIdx-1].settle);
      end
      rdIdx++;
    end
    checkOutput("xfer_count", monQ.size(), expQ.size());
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_drv_enable"}, drv_enable, 0);
    checkOutput({tag, "_drv_is_data"}, drv_is_data, 0);
    checkOutput({tag, "_drv_data"}, drv_data, 0);
    checkOutput({tag, "_drv_flags"}, drv_flags, 0);
    checkOutput({tag, "_wr_ready"}, wr_ready, 0);
    checkOutput({tag, "_init_done"}, init_done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  task automatic flagAt(input int k, input logic [7:0] exp, input string nm);
    @(negedge clk) drv_count = 1'b1;
    @(negedge clk) drv_count = 1'b0;
    repeat (k) @(negedge clk);
    checkOutput(nm, drv_flags, exp);
  endtask

  initial begin
    flagVec_t flagTab[8];
    int endC, n;
    logic [7:0] d;
    bit isCmd;

    flagTab = '{'{0, 8'h00}, '{1, 8'h40}, '{4, 8'h40}, '{5, 8'h60},
                '{839, 8'h60}, '{840, 8'h70}, '{1999, 8'h70}, '{2000, 8'h78}};
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_is_cmd = 1'b0; drv_count = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");

    modelInit();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pwr_wait_busy", busy, 1);
    checkOutput("pwr_wait_ready", wr_ready, 0);

    for (int i = 0; i < 8; i++) flagAt(flagTab[i].k, flagTab[i].flags, "flags_table");
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, 2500);
      flagAt(n, flagsFor(n), "flags_random");
    end

    waitIdle("init_finish");
    checkOutput("init_done", init_done, 1);
    if (monQ.size() >= 6) checkAtLeast("init_done_delay", initDoneCyc - monQ[5].endCyc, SL);
    else failTimeout("init_bytes");
    compareAll();

    applyStimulus(1'b0, 8'h41);
    modelWrite(1'b0, 8'h41);
    waitEnable(1'b1, "char_enable");
    checkOutput("char_data", drv_data, 8'h41);
    checkOutput("char_rs", drv_is_data, 1);
    checkOutput("char_ready_low", wr_ready, 0);
    waitEnable(1'b0, "char_enable_drop");
    endC = cyc;
    waitIdle("char_idle");
    checkAtLeast("ready_after_settle", cyc - endC, SS);
    compareAll();

    applyStimulus(1'b1, 8'h01);
    modelWrite(1'b1, 8'h01);
    for (int i = 0; i < 32; i++) begin
      d = 8'(8'h61 + (i % 26));
      applyStimulus(1'b0, d);
      modelWrite(1'b0, d);
    end
    waitIdle("wrap_idle");
    compareAll();

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 99);
      isCmd = (n >= 70);
      if (n < 70)      d = 8'($urandom_range(32, 126));
      else if (n < 85) d = 8'(128 + 64 * $urandom_range(0, 1) + $urandom_range(0, 15));
      else if (n < 95) d = 8'($urandom_range(1, 2));
      else             d = 8'h0C;
      applyStimulus(isCmd, d);
      modelWrite(isCmd, d);
    end
    waitIdle("random_idle");
    compareAll();

    drvStuck = 1'b1;
    applyStimulus(1'b0, 8'h5A);
    pushExp(1'b1, 8'h5A, 0);
    n = 0;
    while (!err && n < 2 * TMO + 20) begin @(negedge clk); n++; end
    if (!err) failTimeout("timeout_err");
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_enable", drv_enable, 0);
    checkOutput("timeout_ready", wr_ready, 1);
    if (monQ.size() > 0) checkAtLeast("timeout_delay", cyc - monQ[monQ.size()-1].startCyc, TMO);
    drvStuck = 1'b0;
    applyStimulus(1'b0, 8'h42);
    modelWrite(1'b0, 8'h42);
    waitIdle("post_timeout_idle");
    checkOutput("err_sticky", err, 1);
    compareAll();

    applyStimulus(1'b0, 8'h51);
    waitEnable(1'b1, "reset_enable");
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    checkAllZero("mid_reset");
    @(negedge clk) rst = 1'b0;
    monQ.delete(); expQ.delete(); rdIdx = 0;
    modelInit();
    waitIdle("reinit_finish");
    checkOutput("reinit_done", init_done, 1);
    compareAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
